// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner: counts (overlapping) 5-bit pattern hits across a frame of 8-bit words.
// Latency: one LOAD cycle plus 8 SHIFT cycles per word; match_pulse/match_count trail detection by 1 cycle.
// Backpressure: in_ready only in LOAD; the FSM waits there indefinitely while in_valid is low.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start, abort             - frame start (IDLE only), frame abort (any busy state)
//   cfg_pattern, frame_words - configuration latched on an accepted start
//   in_data/in_valid/in_ready- word input handshake
//   busy, done, match_pulse, match_count - status outputs
module pattern_scan_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [4:0]       cfg_pattern,
  input  logic [7:0]       frame_words,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t     state;
  state_t     state_nxt;

  logic [4:0] pattern_q;
  logic [4:0] hist;
  logic [2:0] fill;       // valid bits in hist, saturating at 5
  logic [2:0] bit_idx;
  logic [7:0] sreg;
  logic [7:0] remaining;  // words still to finish, including the one in flight

  logic       cur_bit;
  logic [4:0] hist_nxt;
  logic       match_det;
  logic       last_bit;

  // Four bits of history plus the incoming bit make a full 5-bit window.
  always_comb begin
    cur_bit   = sreg[bit_idx];
    hist_nxt  = {hist[3:0], cur_bit};
    last_bit  = (bit_idx == 3'd0);
    match_det = (state == SHIFT) && (fill >= 3'd4) && (hist_nxt == pattern_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (frame_words == 8'd0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (in_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (last_bit) begin
          state_nxt = (remaining > 8'd1) ? LOAD : DONE;
        end
      end
      DONE: begin
        // An abort landing on the completion cycle suppresses the done pulse.
        done      = ~abort;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q   <= 5'd0;
      hist        <= 5'd0;
      fill        <= 3'd0;
      bit_idx     <= 3'd0;
      sreg        <= 8'd0;
      remaining   <= 8'd0;
      match_pulse <= 1'b0;
      match_count <= '0;
    end else begin
      // Detection in an abort cycle still registers; state only ever leaves SHIFT afterwards.
      match_pulse <= match_det;
      if (match_det && (match_count != '1)) begin
        match_count <= match_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case (state)
        IDLE: begin
          if (start) begin
            pattern_q   <= cfg_pattern;
            remaining   <= frame_words;
            match_count <= '0;
            hist        <= 5'd0;
            fill        <= 3'd0;
          end
        end
        LOAD: begin
          if (!abort && in_valid) begin
            sreg    <= in_data;
            bit_idx <= 3'd7;
          end
        end
        SHIFT: begin
          // History and fill deliberately carry across words so spanning matches count.
          hist    <= hist_nxt;
          bit_idx <= bit_idx - 3'd1;
          if (fill != 3'd5) begin
            fill <= fill + 3'd1;
          end
          if (last_bit) begin
            remaining <= remaining - 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of the match counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  frame start request, sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  terminates the current frame, sampled in every non-IDLE state.
REQ-006 SHALL have port cfg_pattern  input  5  target bit sequence (bit 4 arrives first), latched on accepted start.
REQ-007 SHALL have port frame_words  input  8  number of words in the frame, latched on accepted start.
REQ-008 SHALL have port in_data  input  8  data word, serialised MSB first.
REQ-009 SHALL have port in_valid  input  1  in_data is valid.
REQ-010 SHALL have port in_ready  output  1  controller accepts a word this cycle.
REQ-011 SHALL have port busy  output  1  high in every state other than IDLE.
REQ-012 SHALL have port match_pulse  output  1  one-cycle pulse per detected occurrence.
REQ-013 SHALL have port match_count  output  CNT_W  occurrences counted in the current or last frame.
REQ-014 SHALL have port done  output  1  one-cycle pulse at normal frame completion.

Function
REQ-015 SHALL implement the states IDLE, LOAD, SHIFT and DONE with a registered state.
REQ-016 IDLE SHALL behave as follows: start=1 latches cfg_pattern and frame_words, clears match_count, the 5-bit history and the history fill count, then moves to LOAD; if frame_words=0 it moves to DONE instead.
REQ-017 LOAD SHALL drive in_ready=1 combinationally from the state; when in_valid=1, capture in_data into the shift register, set the bit index to 7 and go to SHIFT; when in_valid=0, stay in LOAD indefinitely.
REQ-018 in_ready SHALL be 0 in every state other than LOAD.
REQ-019 SHIFT SHALL consume exactly one bit per cycle, MSB first, for 8 cycles: history <= {history[3:0], bit} and fill count saturates at 5.
REQ-020 A match SHALL be detected in a SHIFT cycle when the fill count before the shift is >= 4 and the updated history equals the latched pattern; detection is overlapping.
REQ-021 On a match, match_pulse SHALL be registered high in the following cycle only, and match_count SHALL increment in that same following cycle, saturating at 2^CNT_W-1.
REQ-022 History and fill count SHALL persist across word boundaries within a frame, so matches spanning two words count.
REQ-023 After the 8th bit, SHIFT SHALL go to LOAD if more words remain (decrementing the remaining count), else to DONE.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-025 match_count SHALL hold its value in IDLE until the next accepted start.
REQ-026 With in_valid held high, done SHALL assert 9*N+1 cycles after the edge sampling start for N>=1 words, and 1 cycle after for N=0.
REQ-027 abort=1 in LOAD, SHIFT or DONE SHALL force IDLE on the next edge, with no done pulse and match_count frozen; a match detected in the abort cycle still pulses and counts.
REQ-028 abort SHALL have priority over every other transition; start while busy SHALL be ignored.

Reset
REQ-029 rst=1 SHALL, on the next edge and from any state, set state=IDLE, match_count=0, match_pulse=0, done=0, history=0, fill count=0 and remaining=0; in_ready=0 and busy=0 follow.
REQ-030 Reset mid-frame SHALL discard the frame with no done pulse; the first start after release SHALL behave as from power-up.

Verification
REQ-031 The bench SHALL cover: pattern 5'b11010, 1 word 8'hD0 -> one match_pulse, done at cycle 10, match_count=1.
REQ-032 The bench SHALL cover: pattern 5'b10101, 2 words 8'hAA,8'hAA -> 6 match_pulses including cross-word ones, match_count=6, done at cycle 19.
REQ-033 The bench SHALL cover: frame_words=0 -> done one cycle after start, match_count=0, in_ready never high.
REQ-034 The bench SHALL cover: in_valid low for 5 cycles in LOAD -> in_ready stays high, no shift, done delayed exactly 5 cycles.
REQ-035 The bench SHALL cover: abort in the 3rd SHIFT cycle of word 1 -> IDLE next cycle, no done, busy=0; start mid-frame -> ignored.
REQ-036 The bench SHALL cover: pattern 5'b00000 with 40 zero words and CNT_W=8 -> match_count saturates at 255; rst mid-frame -> all outputs 0 the next cycle.
